// File: rtl/multiplicador_secuencial.sv
// Sequential unsigned shift-and-add multiplier.
// Product is {A,MQ}; one iteration per clock over WIDTH clocks.
module multiplicador_secuencial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] MQ
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_a_n;
  logic [WIDTH-1:0] w_mq_n;
  logic [WIDTH-1:0] w_b_n;
  logic             w_c_n;
  logic [CW-1:0]    w_cnt_n;
  logic [WIDTH:0]   w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_mq    <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_mq    <= w_mq_n;
      r_b     <= w_b_n;
      r_c     <= w_c_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_mq_n    = r_mq;
    w_b_n     = r_b;
    w_c_n     = r_c;
    w_cnt_n   = r_cnt;
    // {C,A} before the shift; C carries the add overflow
    w_sum     = {1'b0, r_a};
    if (r_mq[0]) begin
      w_sum = {r_c, r_a} + {1'b0, r_b};
    end
    unique case (r_state)
      IDLE, DONE: begin
        w_state_n = IDLE;
        if (start) begin
          w_state_n = RUN;
          w_b_n     = x;
          w_a_n     = '0;
          w_c_n     = 1'b0;
          w_mq_n    = y;
          w_cnt_n   = '0;
        end
      end
      RUN: begin
        w_c_n   = 1'b0;
        w_a_n   = w_sum[WIDTH:1];
        w_mq_n  = {w_sum[0], r_mq[WIDTH-1:1]};
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          w_state_n = DONE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign A    = r_a;
  assign MQ   = r_mq;

endmodule
